sc_stream_engine: RTL

Parametrised stochastic-computing evaluation engine with handshake control. Each run reseeds an internal maximal-length Fibonacci LFSR and generates NUM_CH comparator-based stochastic bitstreams from latched binary operands. The streams are combined by a selectable gate (pass, AND, OR, XOR), and the ones in the output stream are counted over exactly one LFSR period. The block sits between the binary operand registers and downstream binary logic, and gives an exact binary result for each run.

---
 rtl/sc_stream_engine.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sc_stream_engine.sv
// sc_stream_engine
//   Stochastic-computing evaluation engine. A start request latches NUM_CH
//   binary operands and a combine mode, reseeds a maximal-length Fibonacci
//   LFSR and then runs for exactly one LFSR period (2^WIDTH-1 cycles). Each
//   channel turns its operand into a bitstream by comparing it against a
//   rotated, inverted copy of the LFSR state. The channel streams are merged
//   by the selected gate, and the ones in the merged stream are counted. The
//   count is published on result with a one-cycle done pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, sampled only while idle
//   mode       in   00 pass ch0, 01 AND all, 10 OR all, 11 XOR all
//   input_b    in   packed operands, ch k = [k*WIDTH +: WIDTH]
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse when result updates
//   result     out  ones count of the last completed run
//   bit_out    out  current combined stochastic bit (0 while idle)
//   bit_valid  out  same as busy
//   lfsr_s     out  current LFSR state
module sc_stream_engine #(
    parameter int unsigned       WIDTH  = 8,
    parameter int unsigned       NUM_CH = 2,
    parameter logic [WIDTH-1:0]  TAPS   = 8'b1100_0011,
    parameter logic [WIDTH-1:0]  SEED   = 8'b0000_0001,
    parameter int unsigned       ROT    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [NUM_CH*WIDTH-1:0]   input_b,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          result,
    output logic                      bit_out,
    output logic                      bit_valid,
    output logic [WIDTH-1:0]          lfsr_s
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Cycle index of the final cycle of a run: period minus one = 2^WIDTH-2.
    localparam logic [WIDTH-1:0] LAST_CYC = {{(WIDTH-1){1'b1}}, 1'b0};

    state_t                    state_q;
    logic [WIDTH-1:0]          lfsr_q;
    logic [WIDTH-1:0]          count_q;
    logic [WIDTH-1:0]          cyc_q;
    logic [WIDTH-1:0]          result_q;
    logic                      done_q;
    logic [1:0]                mode_q;
    logic [NUM_CH*WIDTH-1:0]   b_q;

    logic [WIDTH-1:0]          lfsr_d;
    logic [NUM_CH-1:0]         stream;
    logic                      bit_d;

    // Shift toward bit 0; feedback enters at the MSB.
    assign lfsr_d = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};

    // Each channel sees the LFSR rotated by a different amount so the
    // channel streams are decorrelated; inversion keeps every value 0..P-1
    // reachable once per period, giving an exact count of min(b_k, P).
    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            localparam int unsigned SH = (k * ROT) % WIDTH;
            logic [WIDTH-1:0] rnd;
            assign rnd       = ~WIDTH'({lfsr_q, lfsr_q} >> SH);
            assign stream[k] = (rnd < b_q[k*WIDTH +: WIDTH]);
        end
    endgenerate

    always_comb begin
        bit_d = 1'b0;
        if (state_q == RUN) begin
            case (mode_q)
                2'b00:   bit_d = stream[0];
                2'b01:   bit_d = &stream;
                2'b10:   bit_d = |stream;
                default: bit_d = ^stream;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            count_q  <= '0;
            cyc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            mode_q   <= 2'b00;
            b_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        b_q     <= input_b;
                        mode_q  <= mode;
                        lfsr_q  <= SEED;
                        count_q <= '0;
                        cyc_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    count_q <= count_q + WIDTH'(bit_d);
                    lfsr_q  <= lfsr_d;
                    cyc_q   <= cyc_q + WIDTH'(1);
                    // The last bit is folded in directly so result is ready
                    // together with done rather than one cycle later.
                    if (cyc_q == LAST_CYC) begin
                        result_q <= count_q + WIDTH'(bit_d);
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign bit_valid = (state_q == RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign bit_out   = bit_d;
    assign lfsr_s    = lfsr_q;

endmodule
